// File: rtl/marquee_scroller.sv
// Scrolling marquee for a row of 16-segment digits fed from a small writable message store.
// Latency: seg, ptr, step and wrap update one cycle after the step edge (registered).
// Backpressure: none; store writes are accepted every cycle and the display never stalls.
module marquee_scroller #(
    parameter int DIGITS   = 4,
    parameter int MSG_LEN  = 32,
    parameter int TICK_DIV = 8388608
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic                   wr_en,
    input  logic [7:0]             wr_addr,
    input  logic [15:0]            wr_data,
    output logic [DIGITS*16-1:0]   seg,
    output logic                   step,
    output logic                   wrap,
    output logic [7:0]             ptr
);

    localparam int             CW       = $clog2(TICK_DIV);
    localparam int             AW       = $clog2(MSG_LEN);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [7:0]     PTR_LAST = 8'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        MODE_SCROLL = 2'b00,
        MODE_PAUSE  = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    mode_e                    mode_s;
    logic [CW-1:0]            cnt_q;
    logic [DIGITS-1:0][15:0]  digit_q;
    logic                     blink_q;
    logic                     step_edge;
    logic                     wr_ok;
    logic [15:0]              shift_in;

    // The store holds inverted characters so that an all-zero power-up
    // image reads back as blank (16'hFFFF). It is deliberately never reset.
    logic [15:0]              store_n [MSG_LEN];

    assign mode_s    = mode_e'(mode);
    assign step_edge = enable && (cnt_q == CNT_LAST);
    assign wr_ok     = wr_en && ({1'b0, wr_addr} < 9'(MSG_LEN));
    assign shift_in  = ~store_n[ptr[AW-1:0]];
    assign seg       = blink_q ? '1 : digit_q;

    // Message store write port; out-of-range addresses are dropped.
    // Reads of the same address in this cycle still see the old value.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            store_n[wr_addr[AW-1:0]] <= ~wr_data;
        end
    end

    // Step prescaler: free-runs 0..TICK_DIV-1 while enabled, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Display state: digit shift register, message pointer, blink phase and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '1;
            ptr     <= '0;
            blink_q <= 1'b0;
            step    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            step <= step_edge;
            wrap <= step_edge && (mode_s == MODE_SCROLL) && (ptr == PTR_LAST);
            if (step_edge) begin
                case (mode_s)
                    MODE_SCROLL: begin
                        for (int k = 0; k < DIGITS - 1; k++) begin
                            digit_q[k] <= digit_q[k+1];
                        end
                        digit_q[DIGITS-1] <= shift_in;
                        ptr               <= (ptr == PTR_LAST) ? 8'd0 : ptr + 8'd1;
                        blink_q           <= 1'b0;
                    end
                    MODE_PAUSE: begin
                        // Phase can only be 1 after a blink step; clearing it
                        // here guarantees a paused display is never blank.
                        blink_q <= 1'b0;
                    end
                    MODE_BLINK: begin
                        blink_q <= ~blink_q;
                    end
                    MODE_CLEAR: begin
                        digit_q <= '1;
                        ptr     <= 8'd0;
                        blink_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_marquee_scroller.sv
// Bench for marquee_scroller with DIGITS=4, MSG_LEN=3, TICK_DIV=4.
// Each table row is one step: mode, expected display, pointer, wrap and step spacing.
// Expected rows are queued when driven and popped when the step pulse appears.
module tb_marquee_scroller;

    localparam logic [1:0]  SC = 2'b00;
    localparam logic [1:0]  PA = 2'b01;
    localparam logic [1:0]  BK = 2'b10;
    localparam logic [1:0]  CL = 2'b11;
    localparam logic [15:0] F  = 16'hFFFF;

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] seg;
        logic [7:0]  ptr;
        logic        wrap;
        int          gap;
        logic        wr;
        logic [7:0]  waddr;
        logic [15:0] wdata;
        logic        glitch;
    } vec_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        enable  = 1'b0;
    logic [1:0]  mode    = 2'b00;
    logic        wr_en   = 1'b0;
    logic [7:0]  wr_addr = 8'd0;
    logic [15:0] wr_data = 16'd0;
    logic [63:0] seg;
    logic        step;
    logic        wrap;
    logic [7:0]  ptr;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl [24];
    vec_t exp_q [$];

    marquee_scroller #(
        .DIGITS   (4),
        .MSG_LEN  (3),
        .TICK_DIV (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .mode    (mode),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .seg     (seg),
        .step    (step),
        .wrap    (wrap),
        .ptr     (ptr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Pack digits in display order: a is digit 0 (leftmost).
    function automatic logic [63:0] d4(logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
        return {d, c, b, a};
    endfunction

    function automatic vec_t mk(logic [1:0] m, logic [63:0] s, logic [7:0] p, logic w,
                                int g = 4, logic we = 1'b0, logic [7:0] wa = 8'd0,
                                logic [15:0] wd = 16'd0, logic gl = 1'b0);
        vec_t v;
        v.mode = m; v.seg = s; v.ptr = p; v.wrap = w; v.gap = g;
        v.wr = we; v.waddr = wa; v.wdata = wd; v.glitch = gl;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    task automatic wr(logic [7:0] a, logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Drive one row, wait (bounded) for the step pulse, then compare against the queued row.
    task automatic run_vec(int idx, vec_t v);
        int   cyc;
        vec_t e;
        mode = v.mode;
        exp_q.push_back(v);
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (step) begin
                cyc = c;
                break;
            end
            if (v.glitch && c == 1) mode = CL;
            if (v.glitch && c == 2) mode = v.mode;
            if (v.wr && c == v.gap - 1) begin
                wr_en = 1'b1; wr_addr = v.waddr; wr_data = v.wdata;
            end
        end
        wr_en = 1'b0;
        e = exp_q.pop_front();
        check($sformatf("gap[%0d]", idx),  64'(cyc),  64'(e.gap));
        check($sformatf("seg[%0d]", idx),  seg,       e.seg);
        check($sformatf("ptr[%0d]", idx),  64'(ptr),  64'(e.ptr));
        check($sformatf("wrap[%0d]", idx), 64'(wrap), 64'(e.wrap));
    endtask

    // Freeze the counter mid-count for 10 cycles; nothing may move.
    task automatic hold_seq();
        int bad;
        @(negedge clk);
        enable = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (step || wrap || seg !== d4(16'h2, 16'h3, 16'h1, 16'h2)) bad++;
        end
        check("enable_hold", 64'(bad), 64'd0);
        enable = 1'b1;
    endtask

    // Assert reset between clock edges mid-count; outputs must clear with no clk edge.
    task automatic reset_seq();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_seg", seg, {64{1'b1}});
        check("rst_mid_ptr", 64'(ptr), 64'd0);
        check("rst_mid_pulses", 64'({step, wrap}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(SC, d4(F, F, F, 16'h1), 8'd1, 1'b0);
        tbl[1]  = mk(SC, d4(F, F, 16'h1, 16'h2), 8'd2, 1'b0);
        tbl[2]  = mk(SC, d4(F, 16'h1, 16'h2, 16'h3), 8'd0, 1'b1);
        tbl[3]  = mk(SC, d4(16'h1, 16'h2, 16'h3, 16'h1), 8'd1, 1'b0, 4, 1'b0, 8'd0, 16'd0, 1'b1);
        tbl[4]  = mk(SC, d4(16'h2, 16'h3, 16'h1, 16'h2), 8'd2, 1'b0);
        tbl[5]  = mk(BK, {64{1'b1}}, 8'd2, 1'b0, 3);
        tbl[6]  = mk(BK, d4(16'h2, 16'h3, 16'h1, 16'h2), 8'd2, 1'b0);
        tbl[7]  = mk(BK, {64{1'b1}}, 8'd2, 1'b0);
        tbl[8]  = mk(PA, d4(16'h2, 16'h3, 16'h1, 16'h2), 8'd2, 1'b0);
        tbl[9]  = mk(BK, {64{1'b1}}, 8'd2, 1'b0);
        tbl[10] = mk(SC, d4(16'h3, 16'h1, 16'h2, 16'h3), 8'd0, 1'b1);
        tbl[11] = mk(SC, d4(16'h1, 16'h2, 16'h3, 16'h1), 8'd1, 1'b0);
        tbl[12] = mk(SC, d4(16'h2, 16'h3, 16'h1, 16'h2), 8'd2, 1'b0);
        tbl[13] = mk(SC, d4(16'h3, 16'h1, 16'h2, 16'h3), 8'd0, 1'b1, 4, 1'b1, 8'd2, 16'h00AA);
        tbl[14] = mk(SC, d4(16'h1, 16'h2, 16'h3, 16'h1), 8'd1, 1'b0, 4, 1'b1, 8'd5, 16'hBEEF);
        tbl[15] = mk(SC, d4(16'h2, 16'h3, 16'h1, 16'h2), 8'd2, 1'b0);
        tbl[16] = mk(SC, d4(16'h3, 16'h1, 16'h2, 16'hAA), 8'd0, 1'b1);
        tbl[17] = mk(SC, d4(16'h1, 16'h2, 16'hAA, 16'h1), 8'd1, 1'b0);
        tbl[18] = mk(SC, d4(16'h2, 16'hAA, 16'h1, 16'h2), 8'd2, 1'b0);
        tbl[19] = mk(CL, {64{1'b1}}, 8'd0, 1'b0);
        tbl[20] = mk(SC, d4(F, F, F, 16'h1), 8'd1, 1'b0);
        tbl[21] = mk(SC, d4(F, F, F, 16'h1), 8'd1, 1'b0);
        tbl[22] = mk(SC, d4(F, F, 16'h1, 16'h2), 8'd2, 1'b0);
        tbl[23] = mk(SC, d4(F, 16'h1, 16'h2, 16'hAA), 8'd0, 1'b1);

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_seg", seg, {64{1'b1}});
        check("rst_ptr", 64'(ptr), 64'd0);
        check("rst_pulses", 64'({step, wrap}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Load the message with the counter idle.
        wr(8'd0, 16'h0001);
        wr(8'd1, 16'h0002);
        wr(8'd2, 16'h0003);
        check("idle_no_step", 64'(step), 64'd0);

        enable = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 5)  hold_seq();
            if (i == 21) reset_seq();
            run_vec(i, tbl[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
